instruction_fetch: RTL and testbench

Fetch-side initiator for the byte-addressable, combinational-read instruction memory. It owns the program counter and drives the memory's PC input. Each cycle it captures the returned 32-bit instruction word into a small prefetch FIFO and presents {pc, instruction} pairs to decode over a valid/ready handshake. It also accepts branch/jump redirects, which flush the FIFO and reload the PC.

---
 rtl/instruction_fetch_pkg.sv | 25 ++
 rtl/instruction_fetch_if.sv | 38 +++
 rtl/instruction_fetch_fifo.sv | 74 +++++++
 rtl/instruction_fetch.sv | 105 ++++++++++
 tb/tb_instruction_fetch.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Imported by the fetch top level, its prefetch FIFO and the bench.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP    = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory, redirect source and decode.
// Decode handshake: an entry transfers on a rising edge where out_valid and out_ready are both 1;
// while out_valid=1 and out_ready=0 the out_pc/out_instr pair is held unchanged.
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  imem_pc;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over push/pop; storage keeps its stale contents.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch initiator: owns the PC, fills the prefetch FIFO from a combinational imem, handles redirects.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirect raises a sticky flag and halts fetch.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  instruction_fetch_if.master        bus,
  output logic                       misaligned,
  output fetch_state_e               dbg_state
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_state_e      state_q, state_d;

  logic         pop, push, flush, full, empty, halted;
  fetch_entry_t wr_entry, head;

  assign halted = (state_q == ST_HALTED);
  assign pop    = !empty && bus.out_ready;
  assign push   = fetch_en && !bus.redirect_valid && !halted && (!full || pop);
  assign flush  = bus.redirect_valid;

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = pc_q;
    wr_entry.instr = bus.imem_instr;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign bus.imem_pc   = pc_q;
  assign bus.out_valid = !empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign dbg_state     = state_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
`endif

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif
    if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // A bad target leaves the PC untouched and parks the unit until reset.
      if (!is_word_aligned(bus.redirect_pc)) begin
        misaligned_d = 1'b1;
        state_d      = ST_HALTED;
      end else begin
        pc_d = bus.redirect_pc;
      end
`else
      pc_d = bus.redirect_pc & ALIGN_MASK;
`endif
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed test-plan scenarios, then a randomised phase,
// all checked against a cycle model whose FIFO contents live in an expected queue.
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_en;
  logic         misaligned;
  fetch_state_e dbg_state;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .bus        (bus),
    .misaligned (misaligned),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0094_0333;
      32'h0000_0004: return 32'h4139_03b3;
      32'h0000_0008: return 32'h035a_02b3;
      default:       return addr ^ 32'h1357_9bdf;
    endcase
  endfunction

  always_comb bus.imem_instr = mem_word(bus.imem_pc);

  // ---------------- scoreboard / reference model ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_mis;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model using the inputs the DUT sees at this edge.
  task automatic model_step();
    bit pop, push, full;
    if (!reset) begin
      m_pc   = 32'h0;
      m_halt = 1'b0;
      m_mis  = 1'b0;
      exp_q.delete();
      return;
    end
    pop  = (exp_q.size() != 0) && bus.out_ready;
    full = (exp_q.size() == DEPTH);
    push = fetch_en && !bus.redirect_valid && !m_halt && (!full || pop);
    if (bus.redirect_valid) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        m_mis  = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_pc = bus.redirect_pc;
      end
`else
      m_pc = {bus.redirect_pc[31:2], 2'b00};
`endif
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs();
    check("imem_pc", 64'(bus.imem_pc), 64'(m_pc));
    check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    check("misaligned", 64'(misaligned), 64'(m_mis));
    if (exp_q.size() != 0) begin
      check("head", {bus.out_pc, bus.out_instr}, exp_q[0]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    cycle();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_imem_pc", 64'(bus.imem_pc), 64'd0);
    check("rst_misaligned", 64'(misaligned), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_FETCH));
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    reset              = 1'b0;
    fetch_en           = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset state: storage zeroed so head reads 0.
    cycle();
    cycle();
    check("rst_out_pc", 64'(bus.out_pc), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);

    // Streaming at one instruction per cycle.
    reset = 1'b1; fetch_en = 1'b1; bus.out_ready = 1'b1;
    cycle();
    check("seq0_pc", 64'(bus.out_pc), 64'h0);
    check("seq0_instr", 64'(bus.out_instr), 64'h0094_0333);
    cycle();
    check("seq1_pc", 64'(bus.out_pc), 64'h4);
    check("seq1_instr", 64'(bus.out_instr), 64'h4139_03b3);
    cycle();
    check("seq2_pc", 64'(bus.out_pc), 64'h8);
    check("seq2_instr", 64'(bus.out_instr), 64'h035a_02b3);

    // Backpressure: FIFO fills, PC stalls at 8, head held.
    do_reset();
    fetch_en = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_head", {bus.out_pc, bus.out_instr}, {32'h0, 32'h0094_0333});
    end
    check("stall_imem_pc", 64'(bus.imem_pc), 64'h8);
    bus.out_ready = 1'b1;
    cycle();
    check("resume_pc4", 64'(bus.out_pc), 64'h4);
    cycle();
    check("resume_pc8", 64'(bus.out_pc), 64'h8);

    // Redirect while full.
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h10;
    cycle();
    check("redir_flush_valid", 64'(bus.out_valid), 64'd0);
    check("redir_imem_pc", 64'(bus.imem_pc), 64'h10);
    bus.redirect_valid = 1'b0;
    cycle();
    check("redir_valid", 64'(bus.out_valid), 64'd1);
    check("redir_pc", 64'(bus.out_pc), 64'h10);

    // Misaligned redirect.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h6;
    cycle();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag", 64'(misaligned), 64'd1);
    check("mis_pc_held", 64'(bus.imem_pc), 64'h14);
    check("mis_state", 64'(dbg_state), 64'(ST_HALTED));
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("mis_no_valid", 64'(bus.out_valid), 64'd0);
    end
`else
    check("mis_flag", 64'(misaligned), 64'd0);
    check("mis_imem_pc", 64'(bus.imem_pc), 64'h4);
    cycle();
    check("mis_resume_pc", 64'(bus.out_pc), 64'h4);
    check("mis_resume_instr", 64'(bus.out_instr), 64'h4139_03b3);
`endif

    // PC wrap at the top of the address space.
    do_reset();
    fetch_en = 1'b1; bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    check("wrap_top", 64'(bus.out_pc), 64'hFFFF_FFFC);
    cycle();
    check("wrap_zero", 64'(bus.out_pc), 64'h0);
    check("wrap_instr", 64'(bus.out_instr), 64'h0094_0333);

    // Reset mid-stream with two entries buffered.
    bus.out_ready = 1'b0;
    cycle();
    check("full_before_rst", 64'(bus.out_valid), 64'd1);
    do_reset();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 49) != 0);
      fetch_en      = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      r = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | {28'h0, r[3:0]};
      if ($urandom_range(0, 5) == 0) r[1:0] = 2'($urandom_range(1, 3));
      bus.redirect_pc = r;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
